// File: rtl/rom_dump_sequencer.sv
// rom_dump_sequencer
//
// Reads out a complete 556PT5 (3604) or 556PT4 (3601) PROM. For every
// address, the sequencer drives the socket address and operation lines, waits
// ACCESS_CYCLES clocks for the chip to settle, and then captures the data
// lines. It delivers each captured word with its address on a valid/ready
// stream.
//
// Optional feature macro: ROM_DUMP_CHECKSUM_EN
//   defined   - checksum is a 16-bit modulo sum of every transferred word.
//               It is cleared on an accepted start.
//   undefined - no checksum logic is built and checksum is tied to zero.
//
// Parameters:
//   DATA_WIDTH     data word width (8 for 3604, 4 for 3601)
//   ADDRESS_WIDTH  address width (9 for 3604, 8 for 3601)
//   ACCESS_CYCLES  clocks between address setup and data sample, 1..255
//   OP_READ        operation code driven while a dump is running
//   OP_IDLE        operation code driven while idle
//
// Ports:
//   clk           clock
//   reset_n       synchronous, active-low reset
//   start         begin a full dump (sampled in IDLE only)
//   abort         terminate a running dump and return to IDLE
//   operation     chip operation lines V1..V4 (bit0 = V1)
//   address_line  chip address lines
//   data_line_in  chip data lines
//   out_valid     out_data/out_address hold a word
//   out_ready     consumer accepts the word
//   out_data      captured word
//   out_address   address of out_data
//   out_last      out_data is from the all-ones address
//   busy          a dump is in progress
//   done          one-cycle pulse after the last word is transferred
//   checksum      running additive checksum of transferred words
//
// All outputs are registered.

module rom_dump_sequencer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter logic [3:0]  OP_READ       = 4'b1100,
    parameter logic [3:0]  OP_IDLE       = 4'b1111
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              checksum
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_SAMPLE,
        ST_OUTPUT
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [7:0]               WAIT_LOAD = 8'(ACCESS_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_count;

`ifdef ROM_DUMP_CHECKSUM_EN
    logic [15:0] checksum_acc;
    assign checksum = checksum_acc;
`else
    assign checksum = '0;
`endif

    // The current read address is held directly in address_line. That
    // register is zero in IDLE, so it also acts as the cleared start address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            wait_count   <= '0;
            operation    <= OP_IDLE;
            address_line <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_address  <= '0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
            checksum_acc <= '0;
`endif
        end else begin
            done <= 1'b0;

            // abort wins over everything else, including a pending transfer.
            if (abort && (state != ST_IDLE)) begin
                state        <= ST_IDLE;
                operation    <= OP_IDLE;
                address_line <= '0;
                out_valid    <= 1'b0;
                out_last     <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state        <= ST_SETUP;
                            operation    <= OP_READ;
                            address_line <= '0;
                            busy         <= 1'b1;
`ifdef ROM_DUMP_CHECKSUM_EN
                            checksum_acc <= '0;
`endif
                        end
                    end

                    ST_SETUP: begin
                        state      <= ST_WAIT;
                        wait_count <= WAIT_LOAD;
                    end

                    ST_WAIT: begin
                        if (wait_count == '0) begin
                            state <= ST_SAMPLE;
                        end else begin
                            wait_count <= wait_count - 8'd1;
                        end
                    end

                    ST_SAMPLE: begin
                        out_data    <= data_line_in;
                        out_address <= address_line;
                        out_last    <= (address_line == LAST_ADDR);
                        out_valid   <= 1'b1;
                        state       <= ST_OUTPUT;
                    end

                    ST_OUTPUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
                            checksum_acc <= checksum_acc + 16'(out_data);
`endif
                            if (address_line == LAST_ADDR) begin
                                state        <= ST_IDLE;
                                operation    <= OP_IDLE;
                                address_line <= '0;
                                out_last     <= 1'b0;
                                busy         <= 1'b0;
                                done         <= 1'b1;
                            end else begin
                                address_line <= address_line + ADDR_ONE;
                                state        <= ST_SETUP;
                            end
                        end
                    end

                    default: begin
                        state        <= ST_IDLE;
                        operation    <= OP_IDLE;
                        address_line <= '0;
                        out_valid    <= 1'b0;
                        out_last     <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
